// File: rtl/cmm_arb_pkg.sv
// Shared types and the round-robin search helper for the cmm_rr_arb_eb arbiter.
package cmm_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int PTR_W   = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping modulo n; descending loop so the lowest offset wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [PTR_W-1:0]   ptr,
                                       input int                 n);
    rr_pick_t res;
    int       k;
    res = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        k = int'(ptr) + i;
        if (k >= n) begin
          k = k - n;
        end else begin
          k = k;
        end
        if (req[PTR_W'(k)]) begin
          res.found = 1'b1;
          res.idx   = PTR_W'(k);
        end else begin
          res = res;
        end
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cmm_rr_arb_eb_if.sv
// Requester-side and downstream handshake bundle of the cmm_rr_arb_eb arbiter.
interface cmm_rr_arb_eb_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 16
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        i_valid;
  logic [NREQ-1:0]        i_last;
  logic [NREQ*DWIDTH-1:0] i_data;
  logic [NREQ-1:0]        o_ready;
  logic                   o_valid;
  logic                   o_last;
  logic [DWIDTH-1:0]      o_data;
  logic [IDW-1:0]         o_id;
  logic                   i_ready;

  modport slave (
    input  i_valid, i_last, i_data, i_ready,
    output o_ready, o_valid, o_last, o_data, o_id
  );

  modport master (
    output i_valid, i_last, i_data, i_ready,
    input  o_ready, o_valid, o_last, o_data, o_id
  );
endinterface

// File: rtl/cmm_arb_obuf.sv
// Two-entry elastic buffer holding {last, id, data}; accept enable comes from registered count only.
module cmm_arb_obuf #(
  parameter int DWIDTH = 16,
  parameter int IDW    = 2
) (
  input  logic              i_clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_push_last,
  input  logic [IDW-1:0]    i_push_id,
  input  logic [DWIDTH-1:0] i_push_data,
  output logic              o_buf_rdy,
  input  logic              i_ready,
  output logic              o_valid,
  output logic              o_last,
  output logic [IDW-1:0]    o_id,
  output logic [DWIDTH-1:0] o_data
);
  localparam int EW = 1 + IDW + DWIDTH;

  logic [EW-1:0] r_mem [2];
  logic          r_head;
  logic          r_tail;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  assign o_buf_rdy = (r_count < 2'd2);
  assign w_push    = i_push & o_buf_rdy;
  assign w_pop     = (r_count != 2'd0) & i_ready;

  // Storage, pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= {i_push_last, i_push_id, i_push_data};
        r_tail        <= ~r_tail;
      end else begin
        r_tail <= r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end else begin
        r_head <= r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign {o_last, o_id, o_data} = r_mem[r_head];
  assign o_valid                = (r_count != 2'd0);

endmodule

// File: rtl/cmm_rr_arb_eb.sv
// Round-robin arbiter with packet lock sharing one 2-slot elastic buffer among NREQ requesters.
module cmm_rr_arb_eb
  import cmm_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 16
) (
  input logic            i_clk,
  input logic            rst,
  cmm_rr_arb_eb_if.slave bus
);
  localparam int             IDW      = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    w_rr_nxt;
  logic [IDW-1:0]    r_lock_id;
  logic [IDW-1:0]    w_lock_nxt;
  logic [IDW-1:0]    w_sel;
  logic [NREQ-1:0]   w_ready;
  logic              w_push;
  logic              w_buf_rdy;
  logic [DWIDTH-1:0] w_push_data;
  rr_pick_t          w_pick;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDW'(1);
  endfunction

  assign w_pick      = rr_pick(MAX_REQ'(bus.i_valid), PTR_W'(r_rr_ptr), NREQ);
  assign w_push_data = bus.i_data[w_sel*DWIDTH +: DWIDTH];
  assign bus.o_ready = w_ready;

  // Grant, push and next-state decode; ready is forced low while rst is asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_lock_nxt  = r_lock_id;
    w_sel       = r_lock_id;
    w_ready     = '0;
    w_push      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_sel = w_pick.idx[IDW-1:0];
        if (w_pick.found && !rst) begin
          w_ready[w_sel] = w_buf_rdy;
          w_push         = bus.i_valid[w_sel] & w_buf_rdy;
        end else begin
          w_push = 1'b0;
        end
        if (w_push && bus.i_last[w_sel]) begin
          w_rr_nxt = next_idx(w_sel);
        end else if (w_push) begin
          w_state_nxt = ARB_LOCKED;
          w_lock_nxt  = w_sel;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (!rst) begin
          w_ready[r_lock_id] = w_buf_rdy;
          w_push             = bus.i_valid[r_lock_id] & w_buf_rdy;
        end else begin
          w_push = 1'b0;
        end
        if (w_push && bus.i_last[r_lock_id]) begin
          w_state_nxt = ARB_IDLE;
          w_rr_nxt    = next_idx(r_lock_id);
        end else begin
          w_state_nxt = ARB_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state, round-robin pointer and locked owner.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_lock_id <= w_lock_nxt;
    end
  end

  cmm_arb_obuf #(
    .DWIDTH (DWIDTH),
    .IDW    (IDW)
  ) u_obuf (
    .i_clk       (i_clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_last (bus.i_last[w_sel]),
    .i_push_id   (w_sel),
    .i_push_data (w_push_data),
    .o_buf_rdy   (w_buf_rdy),
    .i_ready     (bus.i_ready),
    .o_valid     (bus.o_valid),
    .o_last      (bus.o_last),
    .o_id        (bus.o_id),
    .o_data      (bus.o_data)
  );

endmodule
